// File: rtl/router_pkg.sv
// Shared router constants: byte width, FIFO depth and header field positions.
package router_pkg;

  localparam int ROUTER_DWIDTH      = 8;
  localparam int ROUTER_FIFO_DEPTH  = 16;
  localparam int ROUTER_FIFO_AWIDTH = $clog2(ROUTER_FIFO_DEPTH);

  // Header byte layout: destination address in [1:0], payload length in [7:2].
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int LEN_LSB  = 2;
  localparam int LEN_MSB  = 7;

  // Packet byte counter width (payload length + parity fits in 7 bits).
  localparam int PKT_CNT_W = 7;

endpackage

// File: rtl/router_fifo_ptr.sv
// FIFO pointer register with wrap bit; increments on inc_i, clears on clr_i.
module router_fifo_ptr
  import router_pkg::*;
#(
  parameter int AWIDTH = ROUTER_FIFO_AWIDTH
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [AWIDTH:0] ptr_o
);

  logic [AWIDTH:0] ptr_q;
  logic [AWIDTH:0] ptr_d;

  // Next pointer: flush wins over increment; wraps naturally modulo 2*DEPTH.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router. Stores {header tag, byte},
// tracks packet length on the read side, and supports a soft flush.
// Optional occupancy output is enabled by defining ROUTER_FIFO_OCC_EN.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH  = ROUTER_FIFO_DEPTH,
  parameter int DWIDTH = ROUTER_DWIDTH,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              soft_rst,
  input  logic              we,
  input  logic              re,
  input  logic              lfd_state,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic              full,
  output logic              empty
`ifdef ROUTER_FIFO_OCC_EN
  ,
  output logic [AWIDTH:0]   occupancy
`endif
);

  logic [AWIDTH:0]        wr_ptr;
  logic [AWIDTH:0]        rd_ptr;
  logic                   wr_en;
  logic                   rd_en;
  logic                   lfd_q;
  logic [DWIDTH:0]        mem_q [DEPTH];
  logic [DWIDTH:0]        rd_word;
  logic [DWIDTH-1:0]      dout_q;
  logic [DWIDTH-1:0]      dout_d;
  logic [PKT_CNT_W-1:0]   cnt_q;
  logic [PKT_CNT_W-1:0]   cnt_d;

  // Soft reset masks both ports so a write in the flush cycle is lost.
  assign wr_en = we && !full && !soft_rst;
  assign rd_en = re && !empty && !soft_rst;

  router_fifo_ptr #(.AWIDTH(AWIDTH)) u_wr_ptr (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (soft_rst),
    .inc_i (wr_en),
    .ptr_o (wr_ptr)
  );

  router_fifo_ptr #(.AWIDTH(AWIDTH)) u_rd_ptr (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (soft_rst),
    .inc_i (rd_en),
    .ptr_o (rd_ptr)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]) &&
                 (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]);

`ifdef ROUTER_FIFO_OCC_EN
  assign occupancy = wr_ptr - rd_ptr;
`endif

  // Header tag delayed one cycle to line up with the register stage byte.
  always_ff @(posedge clk) begin
    if (!rstn || soft_rst) begin
      lfd_q <= 1'b0;
    end else begin
      lfd_q <= lfd_state;
    end
  end

  // Storage array; cleared on either reset so flushed data cannot reappear.
  always_ff @(posedge clk) begin
    if (!rstn || soft_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr[AWIDTH-1:0]] <= {lfd_q, din};
    end
  end

  // Read data and packet counter: a header loads length+parity, payload bytes
  // count down; with no read, dout clears once the packet is exhausted.
  always_comb begin
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    rd_word = mem_q[rd_ptr[AWIDTH-1:0]];
    if (rd_en) begin
      dout_d = rd_word[DWIDTH-1:0];
      if (rd_word[DWIDTH]) begin
        cnt_d = PKT_CNT_W'(rd_word[LEN_MSB:LEN_LSB]) + PKT_CNT_W'(1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (cnt_q == '0) begin
      dout_d = '0;
    end
  end

  // Read-side registers.
  always_ff @(posedge clk) begin
    if (!rstn || soft_rst) begin
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rstn;
  logic       soft_rst;
  logic       we;
  logic       re;
  logic       lfd_state;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;
`ifdef ROUTER_FIFO_OCC_EN
  logic [4:0] occupancy;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard: bytes the bench expects the FIFO to have accepted, in order.
  logic [7:0] sb_q[$];
  int         occ_m = 0;

  router_fifo dut (
    .clk       (clk),
    .rstn      (rstn),
    .soft_rst  (soft_rst),
    .we        (we),
    .re        (re),
    .lfd_state (lfd_state),
    .din       (din),
    .dout      (dout),
    .full      (full),
    .empty     (empty)
`ifdef ROUTER_FIFO_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus; pushes the byte if the bench expects it to be
  // accepted given its own occupancy count (full/empty judged pre-edge).
  task automatic drive_cycle(input logic w, input logic r, input logic l, input logic [7:0] d);
    bit rd_ok;
    bit wr_ok;
    we = w; re = r; lfd_state = l; din = d;
    rd_ok = r && (occ_m > 0);
    wr_ok = w && (occ_m < DEPTH);
    @(posedge clk); #1;
    if (wr_ok) sb_q.push_back(d);
    occ_m = occ_m + int'(wr_ok) - int'(rd_ok);
    we = 1'b0; re = 1'b0; lfd_state = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; soft_rst = 1'b0; we = 1'b0; re = 1'b0; lfd_state = 1'b0; din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
    rstn = 1'b1;
    sb_q.delete(); occ_m = 0;
    drive_cycle(0, 0, 0, 8'h00);
  endtask

  task automatic test_packet();
    logic [7:0] pkt [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0F};
    logic [7:0] exp;
    drive_cycle(0, 0, 1, 8'h00);            // header flag leads the byte by one cycle
    foreach (pkt[i]) drive_cycle(1, 0, 0, pkt[i]);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL pkt_not_empty got=%b exp=0", empty); end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 1, 0, 8'h00);
      exp = sb_q.pop_front();
      checks++; if (dout !== exp) begin errors++; $display("FAIL pkt_read%0d got=%h exp=%h", i, dout, exp); end
      if (i == 0) begin
        drive_cycle(0, 0, 0, 8'h00);        // mid-packet idle: count non-zero, dout holds
        checks++; if (dout !== 8'h0D) begin errors++; $display("FAIL pkt_hold got=%h exp=0d", dout); end
      end
    end
    drive_cycle(0, 0, 0, 8'h00);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL pkt_idle_dout got=%h exp=00", dout); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pkt_empty got=%b exp=1", empty); end
  endtask

  task automatic test_full_boundary();
    logic [7:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1, 0, 0, 8'h40 + 8'(i));
      if (i == DEPTH - 2) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early got=%b exp=0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set got=%b exp=1", full); end
    drive_cycle(1, 0, 0, 8'hAA);             // dropped
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_after_drop got=%b exp=1", full); end
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(0, 1, 0, 8'h00);
      exp = sb_q.pop_front();
      checks++; if (dout !== exp) begin errors++; $display("FAIL full_read%0d got=%h exp=%h", i, dout, exp); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got=%b exp=1", empty); end
    drive_cycle(0, 0, 0, 8'h00);
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    int n [2] = '{10, 12};
    foreach (n[k]) begin
      for (int i = 0; i < n[k]; i++) begin
        drive_cycle(1, 0, 0, 8'(i * 7 + k * 100 + 1));
        checks++;
        if (full !== 1'b0 || empty !== 1'b0) begin
          errors++; $display("FAIL wrap_flags_w%0d_%0d full=%b empty=%b exp full=0 empty=0", k, i, full, empty);
        end
      end
      for (int i = 0; i < n[k]; i++) begin
        drive_cycle(0, 1, 0, 8'h00);
        exp = sb_q.pop_front();
        checks++; if (dout !== exp) begin errors++; $display("FAIL wrap_read%0d_%0d got=%h exp=%h", k, i, dout, exp); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty%0d got=%b exp=1", k, empty); end
    end
    drive_cycle(0, 0, 0, 8'h00);
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    for (int i = 0; i < DEPTH; i++) drive_cycle(1, 0, 0, 8'h80 + 8'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL sim_full_set got=%b exp=1", full); end
    drive_cycle(1, 1, 0, 8'hEE);             // read wins, write lost
    exp = sb_q.pop_front();
    checks++; if (dout !== exp) begin errors++; $display("FAIL sim_full_read got=%h exp=%h", dout, exp); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL sim_full_drop got=%b exp=0", full); end
    for (int i = 1; i < DEPTH; i++) begin
      drive_cycle(0, 1, 0, 8'h00);
      exp = sb_q.pop_front();
      checks++; if (dout !== exp) begin errors++; $display("FAIL sim_drain%0d got=%h exp=%h", i, dout, exp); end
    end
    drive_cycle(0, 0, 0, 8'h00);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL sim_pre_idle got=%h exp=00", dout); end
    drive_cycle(1, 1, 0, 8'h5A);             // empty: write stored, read ignored
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL sim_empty_write got=%b exp=0", empty); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL sim_empty_dout got=%h exp=00", dout); end
    drive_cycle(0, 1, 0, 8'h00);
    exp = sb_q.pop_front();
    checks++; if (dout !== exp) begin errors++; $display("FAIL sim_empty_readback got=%h exp=%h", dout, exp); end
    drive_cycle(0, 0, 0, 8'h00);
  endtask

  task automatic test_soft_reset();
    logic [7:0] pkt  [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0F};
    logic [7:0] pkt2 [3] = '{8'h05, 8'h9C, 8'h99};
    logic [7:0] exp;
    drive_cycle(0, 0, 1, 8'h00);
    foreach (pkt[i]) drive_cycle(1, 0, 0, pkt[i]);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 1, 0, 8'h00);
      exp = sb_q.pop_front();
      checks++; if (dout !== exp) begin errors++; $display("FAIL srst_pre%0d got=%h exp=%h", i, dout, exp); end
    end
    soft_rst = 1'b1; we = 1'b1; din = 8'h77;   // write in the flush cycle is lost
    @(posedge clk); #1;
    soft_rst = 1'b0; we = 1'b0;
    sb_q.delete(); occ_m = 0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL srst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL srst_full got=%b exp=0", full); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL srst_dout got=%h exp=00", dout); end
    // Untagged byte after flush: with the count cleared, dout returns to 0 on idle.
    drive_cycle(1, 0, 0, 8'h3C);
    drive_cycle(0, 1, 0, 8'h00);
    exp = sb_q.pop_front();
    checks++; if (dout !== exp) begin errors++; $display("FAIL srst_loose got=%h exp=%h", dout, exp); end
    drive_cycle(0, 0, 0, 8'h00);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL srst_cnt_cleared got=%h exp=00", dout); end
    drive_cycle(0, 0, 1, 8'h00);
    foreach (pkt2[i]) drive_cycle(1, 0, 0, pkt2[i]);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 1, 0, 8'h00);
      exp = sb_q.pop_front();
      checks++; if (dout !== exp) begin errors++; $display("FAIL srst_new%0d got=%h exp=%h", i, dout, exp); end
      if (i == 1) begin
        drive_cycle(0, 0, 0, 8'h00);
        checks++; if (dout !== 8'h9C) begin errors++; $display("FAIL srst_new_hold got=%h exp=9c", dout); end
      end
    end
    drive_cycle(0, 0, 0, 8'h00);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL srst_new_idle got=%h exp=00", dout); end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_full_boundary();
    test_wrap();
    test_simultaneous();
    test_soft_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
